// File: rtl/lr35902_intc_pkg.sv
// Shared constants and types for the LR35902 interrupt controller.
// Source indices, register addresses, vector defaults and FSM state encoding.
package lr35902_intc_pkg;

    localparam int INT_VBLANK = 0;
    localparam int INT_STAT   = 1;
    localparam int INT_TIMER  = 2;
    localparam int INT_SERIAL = 3;
    localparam int INT_JOY    = 4;

    localparam logic [7:0] ADDR_IF = 8'h0F;
    localparam logic [7:0] ADDR_IE = 8'hFF;

    localparam logic [7:0] VEC_BASE_DEF   = 8'h40;
    localparam int         VEC_STRIDE_DEF = 8;

    // state  | meaning
    // IDLE   | no dispatch in progress, waiting for ack
    // ACKED  | vector presented, holding until ack drops
    typedef enum logic {
        IDLE  = 1'b0,
        ACKED = 1'b1
    } intc_state_e;

endpackage

// File: rtl/lr35902_prio_enc.sv
// Lowest-set-bit priority encoder; bit 0 wins. Purely combinational.
module lr35902_prio_enc #(
    parameter int N = 5,
    localparam int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req_i,
    output logic [W-1:0] idx_o,
    output logic         valid_o
);

    always_comb begin
        idx_o   = '0;
        valid_o = |req_i;
        // Scan downward so the lowest set bit is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) idx_o = W'(i);
        end
    end

endmodule

// File: rtl/lr35902_intc.sv
// IF/IE interrupt controller with ack handshake delivering the dispatch vector.
// Per-edge IF order: CPU write, then ack clear, then OR-in of source pulses.
module lr35902_intc
    import lr35902_intc_pkg::*;
#(
    parameter int         NSRC       = 5,
    parameter logic [7:0] VEC_BASE   = VEC_BASE_DEF,
    parameter int         VEC_STRIDE = VEC_STRIDE_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [7:0]      din,
    output logic [7:0]      dout,
    input  logic            read,
    input  logic            write,
    input  logic            cs_if,
    input  logic            cs_ie,
    input  logic [NSRC-1:0] irq_src,
    output logic            int_req,
    output logic            wake,
    input  logic            ack,
    output logic            vec_valid,
    output logic [7:0]      vector
);

    localparam int IW = (NSRC > 1) ? $clog2(NSRC) : 1;

    intc_state_e     state_q, state_d;
    logic [NSRC-1:0] if_q, if_d, if_w, if_clr, pend_w;
    logic [7:0]      ie_q, ie_d;
    logic [7:0]      dout_q, dout_d;
    logic [7:0]      vector_q, vector_d;
    logic            vec_valid_q, vec_valid_d;
    logic [IW-1:0]   enc_idx;
    logic            enc_valid;
    logic [7:0]      if_rd;

    // Arbitration sees post-write registers so a same-edge IE clear cancels the dispatch.
    lr35902_prio_enc #(.N(NSRC)) u_prio (
        .req_i   (pend_w),
        .idx_o   (enc_idx),
        .valid_o (enc_valid)
    );

    always_comb begin
        if_rd             = 8'hFF;
        if_rd[NSRC-1:0]   = if_q;
    end

    always_comb begin
        if_w        = if_q;
        ie_d        = ie_q;
        state_d     = state_q;
        vec_valid_d = vec_valid_q;
        vector_d    = vector_q;
        dout_d      = dout_q;

        if (write && cs_if) if_w = din[NSRC-1:0];
        if (write && cs_ie) ie_d = din;
        pend_w = if_w & ie_d[NSRC-1:0];
        if_clr = if_w;

        case (state_q)
            IDLE: begin
                if (ack) begin
                    state_d     = ACKED;
                    vec_valid_d = 1'b1;
                    if (enc_valid) begin
                        if_clr[enc_idx] = 1'b0;
                        vector_d = 8'(int'(VEC_BASE) + VEC_STRIDE * int'(enc_idx));
                    end else begin
                        vector_d = 8'h00;
                    end
                end
            end
            ACKED: begin
                if (!ack) begin
                    state_d     = IDLE;
                    vec_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        if_d = if_clr | irq_src;

        if (read && cs_if)      dout_d = if_rd;
        else if (read && cs_ie) dout_d = ie_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            if_q        <= '0;
            ie_q        <= 8'h00;
            dout_q      <= 8'hFF;
            vec_valid_q <= 1'b0;
            vector_q    <= 8'h00;
        end else begin
            state_q     <= state_d;
            if_q        <= if_d;
            ie_q        <= ie_d;
            dout_q      <= dout_d;
            vec_valid_q <= vec_valid_d;
            vector_q    <= vector_d;
        end
    end

    assign int_req   = |(if_q & ie_q[NSRC-1:0]);
    assign wake      = int_req;
    assign dout      = dout_q;
    assign vec_valid = vec_valid_q;
    assign vector    = vector_q;

endmodule

// File: tb/tb_lr35902_intc.sv
// Directed self-checking bench for lr35902_intc.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_lr35902_intc;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] din;
    logic [7:0] dout;
    logic       read, write, cs_if, cs_ie;
    logic [4:0] irq_src;
    logic       int_req, wake, ack, vec_valid;
    logic [7:0] vector;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    lr35902_intc dut (
        .clk       (clk),
        .reset     (reset),
        .din       (din),
        .dout      (dout),
        .read      (read),
        .write     (write),
        .cs_if     (cs_if),
        .cs_ie     (cs_ie),
        .irq_src   (irq_src),
        .int_req   (int_req),
        .wake      (wake),
        .ack       (ack),
        .vec_valid (vec_valid),
        .vector    (vector)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr_if(input logic [7:0] d);
        write = 1'b1; cs_if = 1'b1; din = d;
        cyc();
        write = 1'b0; cs_if = 1'b0; din = 8'h00;
    endtask

    task automatic wr_ie(input logic [7:0] d);
        write = 1'b1; cs_ie = 1'b1; din = d;
        cyc();
        write = 1'b0; cs_ie = 1'b0; din = 8'h00;
    endtask

    task automatic rd_if(input string tag, input logic [7:0] exp);
        read = 1'b1; cs_if = 1'b1;
        cyc();
        read = 1'b0; cs_if = 1'b0;
        chk(tag, dout, exp);
    endtask

    task automatic rd_ie(input string tag, input logic [7:0] exp);
        read = 1'b1; cs_ie = 1'b1;
        cyc();
        read = 1'b0; cs_ie = 1'b0;
        chk(tag, dout, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; din = 8'h00; read = 1'b0; write = 1'b0;
        cs_if = 1'b0; cs_ie = 1'b0; irq_src = 5'h00; ack = 1'b0;
        cyc(); cyc();
        reset = 1'b0;
        chk("rst_dout", dout, 8'hFF);
        chk("rst_vvalid", {7'b0, vec_valid}, 8'h00);
        chk("rst_vector", vector, 8'h00);
        chk("rst_intreq", {7'b0, int_req}, 8'h00);
        chk("rst_wake", {7'b0, wake}, 8'h00);
        rd_if("rst_if", 8'hE0);
        rd_ie("rst_ie", 8'h00);

        // Joypad dispatch
        wr_ie(8'h10);
        irq_src = 5'h10; cyc(); irq_src = 5'h00;
        chk("joy_intreq", {7'b0, int_req}, 8'h01);
        chk("joy_wake", {7'b0, wake}, 8'h01);
        ack = 1'b1; cyc();
        chk("joy_vvalid", {7'b0, vec_valid}, 8'h01);
        chk("joy_vector", vector, 8'h60);
        chk("joy_intreq_clr", {7'b0, int_req}, 8'h00);
        cyc();
        chk("joy_hold_vec", vector, 8'h60);
        chk("joy_hold_vv", {7'b0, vec_valid}, 8'h01);
        ack = 1'b0; cyc();
        chk("joy_vv_drop", {7'b0, vec_valid}, 8'h00);
        rd_if("joy_if", 8'hE0);

        // Priority, plus a higher-priority pulse while ACKED stays pending
        wr_ie(8'h1F);
        irq_src = 5'h05; cyc(); irq_src = 5'h00;
        ack = 1'b1; cyc();
        chk("pri_vec0", vector, 8'h40);
        irq_src = 5'h01; cyc(); irq_src = 5'h00;
        chk("pri_hold", vector, 8'h40);
        ack = 1'b0; cyc();
        rd_if("pri_if_a", 8'hE5);
        ack = 1'b1; cyc();
        chk("pri_vec0b", vector, 8'h40);
        ack = 1'b0; cyc();
        rd_if("pri_if_b", 8'hE4);
        ack = 1'b1; cyc();
        chk("pri_vec2", vector, 8'h50);
        ack = 1'b0; cyc();
        rd_if("pri_if_c", 8'hE0);

        // Register access
        wr_if(8'hFF);
        rd_if("reg_if_ff", 8'hFF);
        chk("reg_intreq_sw", {7'b0, int_req}, 8'h01);
        wr_if(8'h00);
        rd_if("reg_if_00", 8'hE0);
        wr_ie(8'hA5);
        rd_ie("reg_ie_a5", 8'hA5);
        chk("reg_intreq_0", {7'b0, int_req}, 8'h00);
        write = 1'b1; read = 1'b1; cs_ie = 1'b1; din = 8'h3C;
        cyc();
        write = 1'b0; read = 1'b0; cs_ie = 1'b0; din = 8'h00;
        chk("reg_rw_same", dout, 8'hA5);
        rd_ie("reg_ie_3c", 8'h3C);

        // Simultaneous events
        wr_ie(8'h1F);
        wr_if(8'hFF);
        write = 1'b1; cs_if = 1'b1; din = 8'h00; irq_src = 5'h02;
        cyc();
        write = 1'b0; cs_if = 1'b0; irq_src = 5'h00;
        rd_if("sim_wr0_src", 8'hE2);
        ack = 1'b1; irq_src = 5'h02; cyc(); irq_src = 5'h00;
        chk("sim_ack_vec", vector, 8'h48);
        ack = 1'b0; cyc();
        rd_if("sim_ack_if", 8'hE2);
        wr_if(8'h00);

        // Cancelled dispatch
        wr_if(8'h01);
        wr_ie(8'h01);
        chk("can_intreq", {7'b0, int_req}, 8'h01);
        write = 1'b1; cs_ie = 1'b1; din = 8'h00; ack = 1'b1;
        cyc();
        write = 1'b0; cs_ie = 1'b0;
        chk("can_vvalid", {7'b0, vec_valid}, 8'h01);
        chk("can_vector", vector, 8'h00);
        ack = 1'b0; cyc();
        rd_if("can_if", 8'hE1);
        rd_ie("can_ie", 8'h00);

        // Reset mid-handshake
        wr_ie(8'h01);
        rd_ie("mid_ie_pre", 8'h01);
        ack = 1'b1; cyc();
        chk("mid_vec", vector, 8'h40);
        wr_if(8'h01);
        reset = 1'b1; cyc(); reset = 1'b0;
        chk("mid_rst_vv", {7'b0, vec_valid}, 8'h00);
        chk("mid_rst_dout", dout, 8'hFF);
        chk("mid_rst_intreq", {7'b0, int_req}, 8'h00);
        cyc();
        chk("mid_reack_vv", {7'b0, vec_valid}, 8'h01);
        chk("mid_reack_vec", vector, 8'h00);
        ack = 1'b0; cyc();
        chk("mid_end_vv", {7'b0, vec_valid}, 8'h00);
        rd_if("mid_if", 8'hE0);
        rd_ie("mid_ie", 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
